mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory port.
// The arbiter attaches through the slave modport; the requester/memory side
// (or a bench) drives the master modport.
//
// Handshake: a requester raises req and holds req plus its address/data
// stable until the cycle in which gnt is high; the transfer is accepted in
// that cycle. A granted read returns exactly one cycle later with rsp_valid
// high for a single cycle; there is no back-pressure on the response.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_address;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_ready;
    logic [31:0] mem_read_data;

    // Outstanding-read owner (0 none, 1 IF, 2 D), exposed for observation.
    logic [1:0]  dbg_rd_owner;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_ready, mem_read_data,
        output if_gnt, if_rsp_valid, if_rsp_data,
               d_gnt, d_rsp_valid, d_rsp_data,
               mem_read, mem_write, mem_funct3, mem_read_address,
               mem_write_address, mem_write_data, dbg_rd_owner
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_ready, mem_read_data,
        input  if_gnt, if_rsp_valid, if_rsp_data,
               d_gnt, d_rsp_valid, d_rsp_data,
               mem_read, mem_write, mem_funct3, mem_read_address,
               mem_write_address, mem_write_data, dbg_rd_owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data (D).
// Grants are combinational, at most one per cycle; the single outstanding
// read is tracked in rd_owner so its response is routed to the right side.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants when both
// sides request; otherwise D always wins over IF.
module mem_port_arbiter #(
    parameter logic [2:0] IF_FUNCT3 = 3'b010
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e      rd_owner_q, rd_owner_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        gnt_if, gnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_gnt: 0 = IF, 1 = D
    logic        last_gnt_q, last_gnt_d;

    // Grant select: alternate on contention, otherwise whoever asks.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (!reset) begin
            if (bus.d_req && bus.if_req) begin
                if (last_gnt_q) gnt_if = 1'b1;
                else            gnt_d  = 1'b1;
            end else if (bus.d_req) begin
                gnt_d = 1'b1;
            end else if (bus.if_req) begin
                gnt_if = 1'b1;
            end
        end
        last_gnt_d = last_gnt_q;
        if (gnt_d)       last_gnt_d = 1'b1;
        else if (gnt_if) last_gnt_d = 1'b0;
    end

    // Round-robin history register.
    always_ff @(posedge clk) begin
        if (reset) last_gnt_q <= 1'b0;
        else       last_gnt_q <= last_gnt_d;
    end
`else
    // Grant select: fixed priority, D over IF (IF may starve).
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (!reset) begin
            if (bus.d_req)       gnt_d  = 1'b1;
            else if (bus.if_req) gnt_if = 1'b1;
        end
    end
`endif

    // Next-state: capture the granted transfer; the outstanding read always
    // retires one cycle after issue unless a new read replaces it.
    always_comb begin
        rd_owner_d = OWN_NONE;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        funct3_d   = funct3_q;
        if (gnt_if) begin
            rd_owner_d = OWN_IF;
            rd_addr_d  = bus.if_addr;
            funct3_d   = IF_FUNCT3;
        end else if (gnt_d) begin
            funct3_d = bus.d_funct3;
            if (bus.d_we) begin
                wr_addr_d = bus.d_addr;
                wr_data_d = bus.d_wdata;
            end else begin
                rd_owner_d = OWN_D;
                rd_addr_d  = bus.d_addr;
            end
        end
    end

    // State and held memory-port fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            funct3_q   <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            funct3_q   <= funct3_d;
        end
    end

    // Memory side: fields pass through in the grant cycle, hold otherwise.
    assign bus.mem_read          = gnt_if | (gnt_d & ~bus.d_we);
    assign bus.mem_write         = gnt_d & bus.d_we;
    assign bus.mem_funct3        = funct3_d;
    assign bus.mem_read_address  = rd_addr_d;
    assign bus.mem_write_address = wr_addr_d;
    assign bus.mem_write_data    = wr_data_d;

    // Requester side: a response with no recorded owner is dropped.
    assign bus.if_gnt       = gnt_if;
    assign bus.d_gnt        = gnt_d;
    assign bus.if_rsp_valid = !reset && bus.mem_ready && (rd_owner_q == OWN_IF);
    assign bus.d_rsp_valid  = !reset && bus.mem_ready && (rd_owner_q == OWN_D);
    assign bus.if_rsp_data  = bus.mem_read_data;
    assign bus.d_rsp_data   = bus.mem_read_data;
    assign bus.dbg_rd_owner = rd_owner_q;

endmodule
